// File: rtl/enc8b10b_pkg.sv
// rtl/enc8b10b_pkg.sv - shared constants, state type and K-code legality for the 8b/10b transmit path
package enc8b10b_pkg;

   localparam logic [7:0] K28_5  = 8'hBC;
   localparam logic       RD_NEG = 1'b0;
   localparam logic       RD_POS = 1'b1;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      ALIGN = 2'd1,
      RUN   = 2'd2
   } state_e;

   // K28.0-K28.7 plus the four K.x.7 codes that have a defined encoding.
   function automatic logic is_legal_k(input logic [7:0] b);
      logic [4:0] x;
      logic [2:0] y;
      x = b[4:0];
      y = b[7:5];
      return (x == 5'd28) ||
             ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
   endfunction

endpackage

// File: rtl/rd_calc.sv
// rtl/rd_calc.sv - running-disparity chain across the 6b and 4b sub-blocks, with LUT sanity checks
module rd_calc (
   input  logic       rd_i,
   input  logic [5:0] lut_6b_i,
   input  logic [3:0] lut_4b_i,
   input  logic       check_i,
   output logic       disp4_o,
   output logic       rd_next_o,
   output logic       err_o
);
   import enc8b10b_pkg::*;

   logic [2:0] ones6;
   logic [2:0] ones4;
   logic       bad6, bad4, sign6_err, sign4_err;

   always_comb begin
      ones6 = '0;
      ones4 = '0;
      for (int i = 0; i < 6; i++) ones6 = ones6 + {2'b00, lut_6b_i[i]};
      for (int i = 0; i < 4; i++) ones4 = ones4 + {2'b00, lut_4b_i[i]};
   end

   assign disp4_o   = (ones6 != 3'd3) ? ~rd_i : rd_i;
   assign rd_next_o = (ones4 != 3'd2) ? ~disp4_o : disp4_o;

   // A legal sub-block is balanced or off by exactly one bit, and only ever pulls RD toward zero.
   assign bad6      = (ones6 < 3'd2) || (ones6 > 3'd4);
   assign bad4      = (ones4 < 3'd1) || (ones4 > 3'd3);
   assign sign6_err = ((ones6 > 3'd3) && (rd_i != RD_NEG)) || ((ones6 < 3'd3) && (rd_i != RD_POS));
   assign sign4_err = ((ones4 > 3'd2) && (disp4_o != RD_NEG)) || ((ones4 < 3'd2) && (disp4_o != RD_POS));

   assign err_o = check_i & (bad6 | bad4 | sign6_err | sign4_err);

endmodule

// File: rtl/enc8b10b_tx_ctrl.sv
// rtl/enc8b10b_tx_ctrl.sv - 8b/10b transmit sequencer: alignment, idle and resync commas, RD tracking
module enc8b10b_tx_ctrl #(
   parameter int ALIGN_LEN   = 16,
   parameter int SYNC_PERIOD = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] in_data,
   input  logic       in_k,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [4:0] enc_x,
   output logic [2:0] enc_y,
   output logic       enc_k,
   output logic       enc_disp6,
   output logic       enc_disp4,
   input  logic [5:0] lut_6b,
   input  logic [3:0] lut_4b,
   output logic [9:0] tx_sym,
   output logic       tx_valid,
   output logic       rd_out,
   output logic       err_k,
   output logic       err_disp,
   input  logic       clear_err
);
   import enc8b10b_pkg::*;

   localparam int AW = (ALIGN_LEN > 1) ? $clog2(ALIGN_LEN) : 1;
   localparam int SW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
   localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_LEN - 1);
   localparam logic [SW-1:0] SYNC_LAST  = SW'((SYNC_PERIOD > 0) ? SYNC_PERIOD - 1 : 0);

   state_e        state_q, state_d;
   logic [AW-1:0] align_cnt_q, align_cnt_d;
   logic [SW-1:0] sym_cnt_q, sym_cnt_d;
   logic [9:0]    tx_sym_q, tx_sym_d;
   logic          tx_valid_q, tx_valid_d;
   logic          rd_q, rd_d;
   logic          err_k_q, err_k_d;
   logic          err_disp_q, err_disp_d;

   logic          force_comma, accept, emit, bad_k;
   logic [7:0]    src_byte;
   logic          src_k;
   logic          rd_next, sym_err;

   assign force_comma = (SYNC_PERIOD != 0) && (sym_cnt_q == SYNC_LAST);
   assign in_ready    = (state_q == RUN) && enable && !force_comma;
   assign accept      = in_ready && in_valid;

   always_comb begin
      src_byte = K28_5;
      src_k    = 1'b1;
      bad_k    = 1'b0;
      if (accept) begin
         if (in_k && !is_legal_k(in_data)) begin
            bad_k = 1'b1;
         end else begin
            src_byte = in_data;
            src_k    = in_k;
         end
      end
   end

   assign enc_x     = src_byte[4:0];
   assign enc_y     = src_byte[7:5];
   assign enc_k     = src_k;
   assign enc_disp6 = rd_q;

   rd_calc u_rd_calc (
      .rd_i      (rd_q),
      .lut_6b_i  (lut_6b),
      .lut_4b_i  (lut_4b),
      .check_i   (emit),
      .disp4_o   (enc_disp4),
      .rd_next_o (rd_next),
      .err_o     (sym_err)
   );

   always_comb begin
      state_d     = state_q;
      align_cnt_d = align_cnt_q;
      sym_cnt_d   = sym_cnt_q;
      emit        = 1'b0;
      if (!enable) begin
         state_d     = OFF;
         align_cnt_d = '0;
         sym_cnt_d   = '0;
      end else begin
         case (state_q)
            OFF: state_d = ALIGN;
            ALIGN: begin
               emit = 1'b1;
               if (align_cnt_q == ALIGN_LAST) begin
                  state_d     = RUN;
                  align_cnt_d = '0;
               end else begin
                  align_cnt_d = align_cnt_q + AW'(1);
               end
            end
            RUN: begin
               emit = 1'b1;
               if (force_comma) sym_cnt_d = '0;
               else if (SYNC_PERIOD != 0) sym_cnt_d = sym_cnt_q + SW'(1);
            end
            default: state_d = OFF;
         endcase
      end
   end

   // On a disparity error the symbol still goes out and RD still advances; only the flag records it.
   always_comb begin
      tx_valid_d = emit;
      tx_sym_d   = emit ? {lut_6b, lut_4b} : tx_sym_q;
      rd_d       = emit ? rd_next : rd_q;
      err_k_d    = bad_k;
      err_disp_d = sym_err | (err_disp_q & ~clear_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= OFF;
         align_cnt_q <= '0;
         sym_cnt_q   <= '0;
         tx_sym_q    <= '0;
         tx_valid_q  <= 1'b0;
         rd_q        <= RD_NEG;
         err_k_q     <= 1'b0;
         err_disp_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         align_cnt_q <= align_cnt_d;
         sym_cnt_q   <= sym_cnt_d;
         tx_sym_q    <= tx_sym_d;
         tx_valid_q  <= tx_valid_d;
         rd_q        <= rd_d;
         err_k_q     <= err_k_d;
         err_disp_q  <= err_disp_d;
      end
   end

   assign tx_sym   = tx_sym_q;
   assign tx_valid = tx_valid_q;
   assign rd_out   = rd_q;
   assign err_k    = err_k_q;
   assign err_disp = err_disp_q;

endmodule

// File: tb/tb_enc8b10b_tx_ctrl.sv
// tb/tb_enc8b10b_tx_ctrl.sv - bench for enc8b10b_tx_ctrl with a LUT model and a symbol-stream reference
module tb_enc8b10b_tx_ctrl;

   localparam int ALIGN_LEN   = 4;
   localparam int SYNC_PERIOD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_k = 1'b0;
   logic       in_valid = 1'b0;
   logic       clear_err = 1'b0;
   logic       force6 = 1'b0;
   logic       in_ready, enc_k, enc_disp6, enc_disp4, tx_valid, rd_out, err_k, err_disp;
   logic [4:0] enc_x;
   logic [2:0] enc_y;
   logic [5:0] lut_6b;
   logic [3:0] lut_4b;
   logic [9:0] tx_sym;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   enc8b10b_tx_ctrl #(.ALIGN_LEN(ALIGN_LEN), .SYNC_PERIOD(SYNC_PERIOD)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data), .in_k(in_k),
      .in_valid(in_valid), .in_ready(in_ready), .enc_x(enc_x), .enc_y(enc_y), .enc_k(enc_k),
      .enc_disp6(enc_disp6), .enc_disp4(enc_disp4), .lut_6b(lut_6b), .lut_4b(lut_4b),
      .tx_sym(tx_sym), .tx_valid(tx_valid), .rd_out(rd_out), .err_k(err_k),
      .err_disp(err_disp), .clear_err(clear_err)
   );

   // Standard 5b/6b and 3b/4b codes, RD- column, abcdei / fghj written MSB first.
   localparam logic [5:0] T6 [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [3:0] T4 [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

   function automatic logic [5:0] lut6(input logic [4:0] x, input logic k, input logic rd);
      logic [5:0] c;
      c = (k && x == 5'd28) ? 6'b001111 : T6[x];
      if (rd && (($countones(c) != 3) || (x == 5'd7 && !k))) c = ~c;
      return c;
   endfunction

   function automatic logic [3:0] lut4(input logic [2:0] y, input logic k, input logic rd);
      logic [3:0] c;
      logic       bal;
      c   = T4[y];
      bal = ($countones(c) == 2) && (y != 3'd3);
      if (!bal && rd) c = ~c;
      else if (bal && k && !rd) c = ~c;
      return c;
   endfunction

   assign lut_6b = force6 ? 6'b111111 : lut6(enc_x, enc_k, enc_disp6);
   assign lut_4b = lut4(enc_y, enc_k, enc_disp4);

   // Reference model: phase 0=off 1=align 2=run, symbol indices as plain integers.
   int         m_phase = 0, m_align = 0, m_run = 0;
   logic       m_rd = 1'b0, m_errd = 1'b0;
   logic       e_valid = 1'b0, e_errk = 1'b0;
   logic [9:0] e_sym = '0;

   function automatic logic legal_k(input logic [7:0] b);
      int x, y;
      x = int'(b[4:0]);
      y = int'(b[7:5]);
      return (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
   endfunction

   task automatic model_reset();
      m_phase = 0; m_align = 0; m_run = 0; m_rd = 1'b0; m_errd = 1'b0;
      e_valid = 1'b0; e_errk = 1'b0; e_sym = '0;
   endtask

   task automatic model_step(input logic en, input logic v, input logic [7:0] d, input logic k,
                             input logic clr, input logic f6, output logic ready_e);
      logic       emit;
      logic [7:0] b;
      logic       bk;
      logic [5:0] s6;
      logic [3:0] s4;
      logic       r6;
      emit = 1'b0; b = 8'hBC; bk = 1'b1; ready_e = 1'b0; e_errk = 1'b0;
      if (!en) begin
         m_phase = 0; m_align = 0; m_run = 0;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         emit = 1'b1;
         m_align++;
         if (m_align == ALIGN_LEN) begin m_phase = 2; m_align = 0; end
      end else begin
         emit = 1'b1;
         ready_e = !((m_run % SYNC_PERIOD) == SYNC_PERIOD - 1);
         if (ready_e && v) begin
            if (k && !legal_k(d)) e_errk = 1'b1;
            else begin b = d; bk = k; end
         end
         m_run++;
      end
      e_valid = emit;
      if (emit) begin
         s6 = f6 ? 6'b111111 : lut6(b[4:0], bk, m_rd);
         r6 = m_rd ^ ($countones(s6) != 3);
         s4 = lut4(b[7:5], bk, r6);
         m_rd = r6 ^ ($countones(s4) != 2);
         e_sym = {s6, s4};
      end
      m_errd = (emit && f6) ? 1'b1 : (clr ? 1'b0 : m_errd);
   endtask

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   logic ready_seen;

   task automatic run_cycle(input logic en, input logic v, input logic [7:0] d, input logic k,
                            input logic clr, input logic f6);
      logic er;
      enable = en; in_valid = v; in_data = d; in_k = k; clear_err = clr; force6 = f6;
      #1;
      model_step(en, v, d, k, clr, f6, er);
      ready_seen = in_ready;
      check("in_ready", in_ready, er);
      @(posedge clk); #1;
      check("tx_valid", tx_valid, e_valid);
      if (e_valid) check("tx_sym", tx_sym, e_sym);
      check("rd_out", rd_out, m_rd);
      check("err_k", err_k, e_errk);
      check("err_disp", err_disp, m_errd);
   endtask

   typedef struct {
      logic       en, v;
      logic [7:0] d;
      logic       k, ready, valid;
      logic [9:0] sym;
      logic       errk;
   } vec_t;

   vec_t       vt [8];
   logic [7:0] pend;
   logic       pend_k;
   int         acc_cnt;
   bit         found;

   initial begin
      vt[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0000000000, 1'b0};
      vt[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'b0011111010, 1'b0};
      vt[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'b1100000101, 1'b0};
      vt[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'b0011111010, 1'b0};
      vt[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'b1100000101, 1'b0};
      vt[5] = '{1'b1, 1'b1, 8'hB5, 1'b0, 1'b1, 1'b1, 10'b1010101010, 1'b0};
      vt[6] = '{1'b1, 1'b1, 8'h0C, 1'b1, 1'b1, 1'b1, 10'b0011111010, 1'b1};
      vt[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 10'b1100000101, 1'b0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_sym", tx_sym, 10'd0);
      check("rst_rd_out", rd_out, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_err_k", err_k, 1'b0);
      check("rst_err_disp", err_disp, 1'b0);
      rst_n = 1'b1;

      // Alignment, a data byte, an illegal K code, then idle fill.
      for (int i = 0; i < 8; i++) begin
         run_cycle(vt[i].en, vt[i].v, vt[i].d, vt[i].k, 1'b0, 1'b0);
         check($sformatf("tbl%0d_ready", i), ready_seen, vt[i].ready);
         check($sformatf("tbl%0d_valid", i), tx_valid, vt[i].valid);
         if (vt[i].valid) check($sformatf("tbl%0d_sym", i), tx_sym, vt[i].sym);
         check($sformatf("tbl%0d_errk", i), err_k, vt[i].errk);
      end

      // in_valid held high across two resync points: exactly two commas in 16 RUN symbols.
      acc_cnt = 0;
      pend = 8'($urandom_range(0, 255));
      for (int i = 0; i < 16; i++) begin
         run_cycle(1'b1, 1'b1, pend, 1'b0, 1'b0, 1'b0);
         if (ready_seen) begin
            acc_cnt++;
            pend = 8'($urandom_range(0, 255));
         end
      end
      check("sync_accepts", 10'(acc_cnt), 10'd14);

      // Corrupt 6b sub-block: sticky error survives clean symbols, then clears.
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("errdisp_set", err_disp, 1'b1);
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("errdisp_held", err_disp, 1'b1);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("errdisp_clr", err_disp, 1'b0);

      // Randomized traffic with upstream hold semantics and occasional link drops.
      pend = 8'($urandom_range(0, 255));
      pend_k = 1'b0;
      for (int i = 0; i < 800; i++) begin
         logic en, v, clr, f6;
         en  = ($urandom_range(0, 59) != 0);
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 19) == 0);
         f6  = ($urandom_range(0, 99) == 0);
         run_cycle(en, v, pend, pend_k, clr, f6);
         if (v && ready_seen) begin
            pend_k = ($urandom_range(0, 3) == 0);
            if (pend_k && $urandom_range(0, 1) == 1)
               pend = {3'($urandom_range(0, 7)), 5'd28};
            else
               pend = 8'($urandom_range(0, 255));
         end
      end

      // Asynchronous reset mid-RUN while RD+, then realignment from RD-.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         run_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         if (m_phase == 2 && m_rd == 1'b1) found = 1'b1;
      end
      check("find_rd_pos", {9'd0, found}, 10'd1);
      check("pre_rst_rd", rd_out, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_valid", tx_valid, 1'b0);
      check("mid_rst_tx_sym", tx_sym, 10'd0);
      check("mid_rst_rd_out", rd_out, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b0);
      check("mid_rst_err_disp", err_disp, 1'b0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("realign_off_valid", tx_valid, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("realign_sym", tx_sym, 10'b0011111010);
      check("realign_rd", rd_out, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
